// File: rtl/stage_prefetch.sv
// stage_prefetch: instruction prefetch queue.
// Issues sequential fetch requests from the PC, parks each granted request in
// a circular queue slot, fills slots as in-order responses return and presents
// the oldest filled slot to decode. Responses still in flight when a redirect
// or flush happens are counted in discard_cnt and dropped on arrival.
module stage_prefetch #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      ILEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_addr,
    output logic [XLEN-1:0] out_addr_plus
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  addr_q  [DEPTH];
    logic [ILEN-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    alloc_ptr;
    logic [PW-1:0]    fill_ptr;
    logic [PW-1:0]    head_ptr;
    logic [CW-1:0]    alloc_cnt;
    logic [CW-1:0]    unfilled_cnt;
    logic [CW-1:0]    discard_cnt;

    logic             grant;
    logic             pop;
    logic             fill;
    logic             drop;
    logic [CW:0]      in_flight;
    logic [CW:0]      redirect_sum;
    logic [CW-1:0]    redirect_discard;

    assign imem_addr     = pc;
    assign out_valid     = (alloc_cnt != '0) && filled_q[head_ptr];
    assign out_instr     = instr_q[head_ptr];
    assign out_addr      = addr_q[head_ptr];
    assign out_addr_plus = out_addr + XLEN'(4);

    // Handshake decode; request eligibility uses registered counts only.
    // Slots between fill_ptr and alloc_ptr are exactly the unfilled ones, so
    // unfilled_cnt alone tells whether a response has somewhere to land.
    always_comb begin
        in_flight        = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
        imem_req         = !rst && !redirect && (in_flight < DEPTH_W);
        grant            = imem_req && imem_gnt;
        pop              = out_valid && out_ready;
        fill             = imem_rvalid && (discard_cnt == '0) && (unfilled_cnt != '0);
        drop             = imem_rvalid && (discard_cnt != '0);
        redirect_sum     = {1'b0, discard_cnt} + {1'b0, unfilled_cnt};
        redirect_discard = CW'(redirect_sum
                               - {{CW{1'b0}}, (imem_rvalid && (redirect_sum != '0))});
    end

    // Queue, pointer, counter and PC state; redirect overrides grant/fill/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            addr_q       <= '{default: '0};
            instr_q      <= '{default: '0};
            filled_q     <= '0;
            alloc_ptr    <= '0;
            fill_ptr     <= '0;
            head_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            discard_cnt  <= '0;
        end else if (redirect) begin
            pc           <= redirect_addr & ~XLEN'(3);
            filled_q     <= '0;
            alloc_ptr    <= '0;
            fill_ptr     <= '0;
            head_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            discard_cnt  <= redirect_discard;
        end else begin
            if (grant) begin
                addr_q[alloc_ptr]   <= pc;
                filled_q[alloc_ptr] <= 1'b0;
                alloc_ptr           <= alloc_ptr + PW'(1);
                pc                  <= pc + XLEN'(4);
            end
            if (fill) begin
                instr_q[fill_ptr]  <= imem_rdata;
                filled_q[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + PW'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            if (drop) begin
                discard_cnt <= discard_cnt - CW'(1);
            end
            alloc_cnt    <= alloc_cnt + CW'(grant) - CW'(pop);
            unfilled_cnt <= unfilled_cnt + CW'(grant) - CW'(fill);
        end
    end

endmodule

// File: tb/tb_stage_prefetch.sv
// tb_stage_prefetch: directed bench for stage_prefetch (default parameters).
// Memory is modelled in-line: granted addresses are queued and, when enabled,
// answered one per cycle in order with instr = addr ^ 32'h5A5A_0000.
module tb_stage_prefetch;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [31:0] out_addr_plus;

    int          checks = 0;
    int          errors = 0;
    int          grants = 0;
    logic [31:0] pend[$];
    bit          resp_en;

    stage_prefetch #(
        .XLEN     (32),
        .ILEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_addr      (out_addr),
        .out_addr_plus (out_addr_plus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time bound in case the design stalls the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: record the grant of the ending cycle, then drive the
    // memory response for the new cycle (latency 1 when the queue is empty).
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        g  = imem_req && imem_gnt;
        ga = imem_addr;
        if (g) grants++;
        @(posedge clk);
        #1;
        if (g) pend.push_back(ga);
        if (resp_en && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = f(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        out_ready = 1'b0; resp_en = 1'b1;
        #2;
        check("rst_req",       imem_req,      0);
        check("rst_valid",     out_valid,     0);
        check("rst_pc",        imem_addr,     0);
        check("rst_out_addr",  out_addr,      0);
        check("rst_out_plus",  out_addr_plus, 4);
        check("rst_out_instr", out_instr,     0);
        tick(); tick();

        // Streaming with ready decode, latency 1.
        rst = 1'b0; imem_gnt = 1'b1; out_ready = 1'b1; #1;
        check("s0_req",   imem_req,  1);
        check("s0_addr",  imem_addr, 0);
        check("s0_valid", out_valid, 0);
        tick(); #1;
        check("s1_addr",  imem_addr, 4);
        check("s1_valid", out_valid, 0);
        tick(); #1;
        check("s2_valid", out_valid,     1);
        check("s2_out",   out_addr,      0);
        check("s2_plus",  out_addr_plus, 4);
        check("s2_instr", out_instr,     f(32'h0));
        check("s2_addr",  imem_addr,     8);
        tick(); #1;
        check("s3_out",   out_addr,      4);
        check("s3_plus",  out_addr_plus, 8);
        check("s3_instr", out_instr,     f(32'h4));
        check("s3_addr",  imem_addr,     12);
        tick(); #1;
        check("s4_out",   out_addr,      8);
        check("s4_plus",  out_addr_plus, 12);

        // Decode stalls: queue fills with 8,12,16,20 and requests stop.
        out_ready = 1'b0;
        tick(); #1;
        check("b5_req",   imem_req,  1);
        check("b5_addr",  imem_addr, 20);
        check("b5_out",   out_addr,  8);
        tick(); #1;
        check("b6_req",   imem_req,  0);
        check("b6_out",   out_addr,  8);
        tick(); #1;
        check("b7_req",   imem_req,  0);
        check("b7_valid", out_valid, 1);
        tick(); #1;
        check("b8_req",   imem_req,  0);
        check("b8_instr", out_instr, f(32'h8));

        // Reset pulse between edges with a full queue.
        #1; rst = 1'b1; #1;
        check("ar_valid", out_valid,     0);
        check("ar_req",   imem_req,      0);
        check("ar_out",   out_addr,      0);
        check("ar_plus",  out_addr_plus, 4);
        pend.delete();
        tick();
        rst = 1'b0; grants = 0; #1;
        check("r0_req",  imem_req,  1);
        check("r0_addr", imem_addr, 0);
        tick(); #1;
        check("r1_addr", imem_addr, 4);
        tick(); #1;
        check("r2_valid", out_valid, 1);
        check("r2_out",   out_addr,  0);
        check("r2_addr",  imem_addr, 8);
        tick(); #1;
        check("r3_addr", imem_addr, 12);
        tick(); #1;
        check("r4_req",  imem_req,  0);
        tick(); #1;
        check("r5_req",  imem_req,  0);
        // Stray response with nothing unfilled must be ignored.
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; #1;
        tick(); #1;
        check("r6_grants", grants,    4);
        check("r6_valid",  out_valid, 1);
        check("r6_out",    out_addr,  0);
        check("r6_instr",  out_instr, f(32'h0));
        out_ready = 1'b1; #1;
        check("r6_req_pop", imem_req, 0);
        tick(); #1;
        check("r7_out",   out_addr,  4);
        check("r7_req",   imem_req,  1);
        check("r7_addr",  imem_addr, 16);
        tick(); #1;
        check("r8_out",   out_addr,  8);
        tick(); #1;
        check("r9_out",   out_addr,  12);
        tick(); #1;
        check("r10_out",   out_addr,  16);
        check("r10_instr", out_instr, f(32'h10));
        tick(); #1;
        check("r11_out",  out_addr,  20);

        // Redirect to 0x104 with three unfilled requests outstanding.
        #1; rst = 1'b1; #1;
        pend.delete(); resp_en = 1'b0;
        tick();
        rst = 1'b0; #1;
        check("d0_addr", imem_addr, 0);
        tick(); tick(); tick(); #1;
        check("d3_valid", out_valid, 0);
        check("d3_addr",  imem_addr, 12);
        redirect = 1'b1; redirect_addr = 32'h0000_0104; #1;
        check("d3_req_redir", imem_req, 0);
        resp_en = 1'b1;
        tick();
        redirect = 1'b0; #1;
        check("p1_valid", out_valid, 0);
        check("p1_req",   imem_req,  1);
        check("p1_addr",  imem_addr, 32'h104);
        tick(); #1;
        check("p2_valid", out_valid, 0);
        check("p2_addr",  imem_addr, 32'h108);
        tick(); #1;
        check("p3_valid", out_valid, 0);
        check("p3_addr",  imem_addr, 32'h10C);
        tick(); #1;
        check("p4_valid", out_valid, 0);
        check("p4_addr",  imem_addr, 32'h110);
        tick(); #1;
        check("p5_valid", out_valid,     1);
        check("p5_out",   out_addr,      32'h104);
        check("p5_instr", out_instr,     f(32'h104));
        check("p5_plus",  out_addr_plus, 32'h108);
        check("p5_req",   imem_req,      0);
        tick(); #1;
        check("p6_out",   out_addr,  32'h108);
        check("p6_addr",  imem_addr, 32'h114);
        tick(); #1;
        check("p7_out",   out_addr,  32'h10C);
        check("p7_instr", out_instr, f(32'h10C));

        // Unaligned redirect target while a response arrives.
        redirect = 1'b1; redirect_addr = 32'h0000_0203; #1;
        tick();
        redirect = 1'b0; #1;
        check("q1_valid", out_valid, 0);
        check("q1_req",   imem_req,  1);
        check("q1_addr",  imem_addr, 32'h200);
        tick(); #1;
        check("q2_valid", out_valid, 0);
        check("q2_addr",  imem_addr, 32'h204);
        tick(); #1;
        check("q3_valid", out_valid, 1);
        check("q3_out",   out_addr,  32'h200);
        check("q3_instr", out_instr, f(32'h200));

        // PC wrap at the top of the address space.
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC; #1;
        tick();
        redirect = 1'b0; #1;
        check("w1_valid", out_valid, 0);
        check("w1_addr",  imem_addr, 32'hFFFF_FFFC);
        tick(); #1;
        check("w2_addr",  imem_addr, 0);
        tick(); #1;
        check("w3_valid", out_valid,     1);
        check("w3_out",   out_addr,      32'hFFFF_FFFC);
        check("w3_plus",  out_addr_plus, 0);
        check("w3_instr", out_instr,     f(32'hFFFF_FFFC));
        tick(); #1;
        check("w4_out",   out_addr,      0);
        check("w4_plus",  out_addr_plus, 4);
        check("w4_instr", out_instr,     f(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
